// File: rtl/spectrum_pkg.sv
// ============================================================================
// Module      : spectrum_pkg
// Description : Shared sequencer state encoding and statistics counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spectrum_pkg;

  localparam int FRAME_CNT_W = 16;
  localparam int DROP_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_RUN      = 3'd2,
    ST_WAIT_VGA = 3'd3,
    ST_SWAP     = 3'd4
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_watchdog.sv
// ============================================================================
// Module      : seq_watchdog
// Description : Counts enabled cycles from zero; expired flags the last allowed
//               cycle (count == TIMEOUT_CYCLES-1) while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != c_last)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = enable && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/analysis_sequencer.sv
// ============================================================================
// Module      : analysis_sequencer
// Description : Buffer -> FFT -> VGA buffer-swap sequencer with decimation,
//               FFT watchdog and optional statistics (macro SEQ_STATS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module analysis_sequencer
  import spectrum_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int DECIM_W        = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   buff_start_i,
  output logic                   fft_start_o,
  input  logic                   fft_done_i,
  input  logic                   vga_busy_i,
  output logic                   vga_swap_o,
  input  logic                   hold_i,
  input  logic [DECIM_W-1:0]     decim_i,
  output logic                   busy_o,
  output logic                   timeout_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic [DROP_CNT_W-1:0]  drop_cnt_o
);

  seq_state_t         r_state;
  seq_state_t         w_next_state;
  logic [DECIM_W-1:0] r_decim_cnt;
  logic [DECIM_W-1:0] w_decim_cnt_next;
  logic               w_timeout_set;
  logic               w_accept;
  logic               w_wd_expired;
  logic               r_fft_start;
  logic               r_vga_swap;
  logic               r_busy;
  logic               r_timeout;

  assign w_accept = buff_start_i && !hold_i && (r_state == ST_IDLE);

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (r_state != ST_RUN),
    .enable  (r_state == ST_RUN),
    .expired (w_wd_expired)
  );

  always_comb begin
    w_next_state     = r_state;
    w_decim_cnt_next = r_decim_cnt;
    w_timeout_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          // >= so that lowering decim_i below the running count fires at once
          if (r_decim_cnt >= decim_i) begin
            w_decim_cnt_next = '0;
            w_next_state     = ST_START;
          end else begin
            w_decim_cnt_next = r_decim_cnt + 1'b1;
          end
        end
      end
      ST_START: w_next_state = ST_RUN;
      ST_RUN: begin
        if (fft_done_i) begin
          w_next_state = ST_WAIT_VGA;
        end else if (w_wd_expired) begin
          w_next_state  = ST_IDLE;
          w_timeout_set = 1'b1;
        end
      end
      ST_WAIT_VGA: begin
        if (!vga_busy_i) begin
          w_next_state = ST_SWAP;
        end
      end
      ST_SWAP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_decim_cnt <= '0;
      r_fft_start <= 1'b0;
      r_vga_swap  <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_decim_cnt <= w_decim_cnt_next;
      r_fft_start <= (w_next_state == ST_START);
      r_vga_swap  <= (w_next_state == ST_SWAP);
      r_busy      <= (w_next_state != ST_IDLE);
      r_timeout   <= r_timeout | w_timeout_set;
    end
  end

  assign fft_start_o = r_fft_start;
  assign vga_swap_o  = r_vga_swap;
  assign busy_o      = r_busy;
  assign timeout_o   = r_timeout;

`ifdef SEQ_STATS_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic [DROP_CNT_W-1:0]  r_drop_cnt;
  logic                   w_drop;

  assign w_drop = buff_start_i && (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if ((w_next_state == ST_SWAP) && (r_state == ST_WAIT_VGA)) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign frame_cnt_o = r_frame_cnt;
  assign drop_cnt_o  = r_drop_cnt;
`else
  assign frame_cnt_o = '0;
  assign drop_cnt_o  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_analysis_sequencer.sv
// ============================================================================
// Module      : tb_analysis_sequencer
// Description : Scenario bench for analysis_sequencer with an arithmetic
//               reference model of pulse timing, decimation and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_analysis_sequencer;

  localparam int TO = 40;
`ifdef SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        buff_start_i;
  logic        fft_done_i;
  logic        vga_busy_i;
  logic        hold_i;
  logic [3:0]  decim_i;
  logic        fft_start_o;
  logic        vga_swap_o;
  logic        busy_o;
  logic        timeout_o;
  logic [15:0] frame_cnt_o;
  logic [7:0]  drop_cnt_o;

  int checks = 0;
  int failures = 0;
  int t, n_start, n_swap, last_start, last_swap;
  int exp_frames, exp_drops;

  analysis_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .DECIM_W(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .buff_start_i (buff_start_i),
    .fft_start_o  (fft_start_o),
    .fft_done_i   (fft_done_i),
    .vga_busy_i   (vga_busy_i),
    .vga_swap_o   (vga_swap_o),
    .hold_i       (hold_i),
    .decim_i      (decim_i),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .frame_cnt_o  (frame_cnt_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic int exp_frame_val();
    return STATS ? (exp_frames & 16'hFFFF) : 0;
  endfunction

  function automatic int exp_drop_val();
    return STATS ? ((exp_drops > 255) ? 255 : exp_drops) : 0;
  endfunction

  // Advance to the next falling edge and log output pulses with their cycle.
  task automatic step();
    @(negedge clk);
    t++;
    if (fft_start_o) begin n_start++; last_start = t; end
    if (vga_swap_o)  begin n_swap++;  last_swap  = t; end
  endtask

  task automatic clear_obs();
    t = 0; n_start = 0; n_swap = 0; last_start = -1; last_swap = -1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; buff_start_i = 0; fft_done_i = 0; vga_busy_i = 0; hold_i = 0; decim_i = 0;
    step(); step();
    rst = 1'b0;
    exp_frames = 0; exp_drops = 0;
    clear_obs();
  endtask

  task automatic pulse_buff();
    buff_start_i = 1'b1; step(); buff_start_i = 1'b0;
  endtask

  task automatic pulse_done();
    fft_done_i = 1'b1; step(); fft_done_i = 1'b0;
  endtask

  // Called right after a start pulse; delay >= 1 so done lands in RUN.
  task automatic finish_frame(input int delay, output bit ok);
    int s0;
    for (int i = 0; i < delay; i++) step();
    s0 = n_swap;
    pulse_done();
    for (int i = 0; i < 8 && n_swap == s0; i++) step();
    ok = (n_swap != s0);
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (fft_start_o !== 1'b0) begin failures++; $display("FAIL reset_fft_start got=%b exp=0", fft_start_o); end
    checks++; if (vga_swap_o !== 1'b0) begin failures++; $display("FAIL reset_vga_swap got=%b exp=0", vga_swap_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
    checks++; if (frame_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt_o); end
    checks++; if (drop_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt_o); end
  endtask

  task automatic test_single_frame();
    apply_reset();
    while (t < 10) step();
    pulse_buff();
    checks++; if (last_start != 11) begin failures++; $display("FAIL single_start_cycle got=%0d exp=11", last_start); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy_o); end
    while (t < 50) step();
    pulse_done();
    step();
    exp_frames = 1;
    checks++; if (last_swap != 52 || n_swap != 1) begin failures++; $display("FAIL single_swap_cycle got=%0d n=%0d exp=52 n=1", last_swap, n_swap); end
    checks++; if (frame_cnt_o !== 16'(exp_frame_val())) begin failures++; $display("FAIL single_frame_cnt got=%0d exp=%0d", frame_cnt_o, exp_frame_val()); end
    step();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_decimation();
    for (int trial = 0; trial < 6; trial++) begin
      int d, np, s0, exp_starts;
      bit got, want, ok;
      d  = (trial == 0) ? 2 : $urandom_range(0, 4);
      np = (trial == 0) ? 6 : $urandom_range(3, 10);
      apply_reset();
      decim_i = 4'(d);
      exp_starts = 0;
      for (int k = 1; k <= np; k++) begin
        s0 = n_start;
        pulse_buff();
        got  = (n_start != s0);
        want = ((k % (d + 1)) == 0);
        checks++;
        if (got !== want) begin failures++; $display("FAIL decim_start trial=%0d d=%0d pulse=%0d got=%b exp=%b", trial, d, k, got, want); end
        if (want) begin exp_starts++; exp_frames++; end
        if (got) finish_frame($urandom_range(1, 20), ok);
        for (int g = $urandom_range(0, 3); g > 0; g--) step();
      end
      checks++; if (n_start != exp_starts) begin failures++; $display("FAIL decim_total trial=%0d got=%0d exp=%0d", trial, n_start, exp_starts); end
      checks++; if (frame_cnt_o !== 16'(exp_frame_val())) begin failures++; $display("FAIL decim_frames trial=%0d got=%0d exp=%0d", trial, frame_cnt_o, exp_frame_val()); end
    end
  endtask

  task automatic test_decim_lower();
    bit ok;
    apply_reset();
    decim_i = 4'd3;
    pulse_buff(); pulse_buff(); step();
    decim_i = 4'd1;
    pulse_buff();
    checks++; if (n_start != 1) begin failures++; $display("FAIL decim_lower_start got=%0d exp=1", n_start); end
    if (n_start == 1) finish_frame(3, ok);
    pulse_buff();
    checks++; if (n_start != 1) begin failures++; $display("FAIL decim_lower_skip got=%0d exp=1", n_start); end
    pulse_buff();
    checks++; if (n_start != 2) begin failures++; $display("FAIL decim_lower_next got=%0d exp=2", n_start); end
  endtask

  task automatic test_drops_and_hold();
    int n_run;
    bit ok;
    apply_reset();
    decim_i = 4'd1;
    hold_i = 1'b1;
    pulse_buff(); pulse_buff(); pulse_buff();
    hold_i = 1'b0;
    checks++; if (n_start != 0 || drop_cnt_o !== 8'd0) begin failures++; $display("FAIL hold_idle starts=%0d drops=%0d exp=0/0", n_start, drop_cnt_o); end
    pulse_buff();
    checks++; if (n_start != 0) begin failures++; $display("FAIL hold_counter_kept got=%0d exp=0", n_start); end
    pulse_buff();
    checks++; if (n_start != 1) begin failures++; $display("FAIL hold_then_start got=%0d exp=1", n_start); end
    vga_busy_i = 1'b1;
    n_run = $urandom_range(5, 20);
    for (int i = 0; i < n_run; i++) begin pulse_buff(); exp_drops++; end
    pulse_done();
    while (exp_drops < 300) begin
      hold_i = 1'($urandom_range(0, 1));
      pulse_buff();
      exp_drops++;
      if (exp_drops == 100) begin
        checks++; if (drop_cnt_o !== 8'(exp_drop_val())) begin failures++; $display("FAIL drop_mid got=%0d exp=%0d", drop_cnt_o, exp_drop_val()); end
      end
    end
    hold_i = 1'b0;
    step();
    checks++; if (drop_cnt_o !== 8'(exp_drop_val())) begin failures++; $display("FAIL drop_sat got=%0d exp=%0d", drop_cnt_o, exp_drop_val()); end
    checks++; if (busy_o !== 1'b1 || n_start != 1 || n_swap != 0) begin failures++; $display("FAIL drop_state busy=%b starts=%0d swaps=%0d exp=1/1/0", busy_o, n_start, n_swap); end
    vga_busy_i = 1'b0;
    for (int i = 0; i < 5 && n_swap == 0; i++) step();
    step();
    exp_frames++;
    checks++; if (n_swap != 1 || frame_cnt_o !== 16'(exp_frame_val())) begin failures++; $display("FAIL drop_release swaps=%0d frames=%0d exp=1/%0d", n_swap, frame_cnt_o, exp_frame_val()); end
    pulse_buff();
    checks++; if (n_start != 1) begin failures++; $display("FAIL drop_decim_kept got=%0d exp=1", n_start); end
    pulse_buff();
    checks++; if (n_start != 2) begin failures++; $display("FAIL drop_decim_next got=%0d exp=2", n_start); end
    if (n_start == 2) finish_frame(2, ok);
  endtask

  task automatic test_hold_mid_frame();
    bit ok;
    apply_reset();
    pulse_buff();
    step(); step(); step();
    hold_i = 1'b1;
    finish_frame(1, ok);
    hold_i = 1'b0;
    checks++; if (ok !== 1'b1 || n_swap != 1) begin failures++; $display("FAIL hold_mid_frame swapped=%b n=%0d exp=1", ok, n_swap); end
  endtask

  task automatic test_vga_wait();
    int f;
    apply_reset();
    vga_busy_i = 1'b1;
    pulse_buff();
    for (int i = $urandom_range(1, 10); i > 0; i--) step();
    pulse_done();
    for (int i = 0; i < 100; i++) step();
    checks++; if (n_swap != 0 || busy_o !== 1'b1) begin failures++; $display("FAIL vga_hold swaps=%0d busy=%b exp=0/1", n_swap, busy_o); end
    f = t;
    vga_busy_i = 1'b0;
    step(); step();
    checks++; if (last_swap != f + 1) begin failures++; $display("FAIL vga_release_cycle got=%0d exp=%0d", last_swap, f + 1); end
  endtask

  task automatic test_done_ignored();
    apply_reset();
    pulse_done();
    step(); step(); step();
    checks++; if (n_swap != 0 || busy_o !== 1'b0 || n_start != 0) begin failures++; $display("FAIL done_in_idle swaps=%0d busy=%b starts=%0d exp=0/0/0", n_swap, busy_o, n_start); end
  endtask

  task automatic test_timeout();
    int ts, s0;
    bit ok;
    apply_reset();
    pulse_buff();
    ts = last_start;
    while (t < ts + TO) step();
    pulse_done();
    step();
    checks++; if (last_swap != ts + TO + 2 || timeout_o !== 1'b0) begin failures++; $display("FAIL timeout_edge_done swap=%0d to=%b exp=%0d/0", last_swap, timeout_o, ts + TO + 2); end
    step();
    pulse_buff();
    ts = last_start;
    while (t < ts + TO) step();
    checks++; if (busy_o !== 1'b1 || timeout_o !== 1'b0) begin failures++; $display("FAIL timeout_before busy=%b to=%b exp=1/0", busy_o, timeout_o); end
    s0 = n_swap;
    step();
    checks++; if (busy_o !== 1'b0 || timeout_o !== 1'b1) begin failures++; $display("FAIL timeout_expire busy=%b to=%b exp=0/1", busy_o, timeout_o); end
    step();
    pulse_done();
    step(); step(); step();
    checks++; if (n_swap != s0 || timeout_o !== 1'b1) begin failures++; $display("FAIL timeout_late_done swaps=%0d to=%b exp=%0d/1", n_swap, timeout_o, s0); end
    pulse_buff();
    finish_frame(4, ok);
    checks++; if (ok !== 1'b1 || timeout_o !== 1'b1) begin failures++; $display("FAIL timeout_sticky swapped=%b to=%b exp=1/1", ok, timeout_o); end
  endtask

  task automatic test_reset_mid_run();
    int s0;
    apply_reset();
    hold_i = 1'b0;
    pulse_buff();
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    checks++; if ({fft_start_o, vga_swap_o, busy_o, timeout_o} !== 4'b0 || frame_cnt_o !== 16'd0 || drop_cnt_o !== 8'd0) begin
      failures++; $display("FAIL async_reset outs=%b frame=%0d drop=%0d exp=0", {fft_start_o, vga_swap_o, busy_o, timeout_o}, frame_cnt_o, drop_cnt_o);
    end
    step(); step();
    rst = 1'b0;
    s0 = n_swap;
    pulse_done();
    for (int i = 0; i < 5; i++) step();
    checks++; if (n_swap != s0 || {fft_start_o, vga_swap_o, busy_o, timeout_o} !== 4'b0 || frame_cnt_o !== 16'd0 || drop_cnt_o !== 8'd0) begin
      failures++; $display("FAIL reset_mid_run swaps=%0d outs=%b frame=%0d drop=%0d exp=%0d/0", n_swap, {fft_start_o, vga_swap_o, busy_o, timeout_o}, frame_cnt_o, drop_cnt_o, s0);
    end
    pulse_buff();
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL reset_mid_run_restart busy=%b exp=1", busy_o); end
  endtask

  initial begin
    rst = 1'b1; buff_start_i = 0; fft_done_i = 0; vga_busy_i = 0; hold_i = 0; decim_i = 0;
    test_reset();
    test_single_frame();
    test_decimation();
    test_decim_lower();
    test_drops_and_hold();
    test_hold_mid_frame();
    test_vga_wait();
    test_done_ignored();
    test_timeout();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit reached t=%0d", t);
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire

// File: doc/analysis_sequencer.md
ANALYSIS_SEQUENCER -- requirements
Module: analysis_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1048576, max clk cycles allowed between fft_start_o and fft_done_i.
REQ-002 SHALL have parameter DECIM_W, default 4, width of decim_i.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz), sole clock domain.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port buff_start_i  input  1  one-cycle pulse: codec sample buffer full.
REQ-006 SHALL have port fft_start_o  output  1  one-cycle pulse starting the FFT block.
REQ-007 SHALL have port fft_done_i  input  1  one-cycle pulse: FFT results written.
REQ-008 SHALL have port vga_busy_i  input  1  high while VGA is mid-frame on the display buffer.
REQ-009 SHALL have port vga_swap_o  output  1  one-cycle pulse: swap VGA display buffers.
REQ-010 SHALL have port hold_i  input  1  freeze display; new buffers ignored.
REQ-011 SHALL have port decim_i  input  DECIM_W  process one buffer in every decim_i+1.
REQ-012 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-013 SHALL have port timeout_o  output  1  sticky FFT-timeout error flag.
REQ-014 SHALL have port frame_cnt_o  output  16  completed-frame counter.
REQ-015 SHALL have port drop_cnt_o  output  8  saturating count of buffers dropped while busy.

Function
REQ-016 SHALL implement states IDLE, START, RUN, WAIT_VGA, SWAP; all outputs registered.
REQ-017 IDLE: buff_start_i with hold_i=0 SHALL advance the decimation counter; if counter equals decim_i, clear it and go to START, else increment and stay in IDLE.
REQ-018 START SHALL last one cycle with fft_start_o=1, then go to RUN; accepted buff_start_i at cycle N gives fft_start_o at N+1.
REQ-019 RUN SHALL count cycles from 0; fft_done_i moves to WAIT_VGA; count reaching TIMEOUT_CYCLES-1 without fft_done_i sets timeout_o and returns to IDLE with no swap.
REQ-020 fft_done_i and timeout expiry in the same cycle SHALL be treated as done (no timeout).
REQ-021 WAIT_VGA SHALL go to SWAP in the first cycle vga_busy_i=0; it SHALL wait indefinitely otherwise.
REQ-022 SWAP SHALL last one cycle with vga_swap_o=1, increment frame_cnt_o (wrapping 0xFFFF->0), then go to IDLE; earliest swap is 2 cycles after fft_done_i.
REQ-023 buff_start_i in any state other than IDLE SHALL increment drop_cnt_o, saturating at 255; it never alters the decimation counter.
REQ-024 buff_start_i while hold_i=1 in IDLE SHALL be ignored and not counted as a drop.
REQ-025 hold_i asserted outside IDLE SHALL NOT abort the frame; the frame completes including SWAP.
REQ-026 fft_done_i outside RUN SHALL be ignored.
REQ-027 decim_i SHALL be sampled on each IDLE buff_start_i; decim_i=0 processes every buffer.
REQ-028 If decim_i is lowered below the current counter value, the next accepted pulse SHALL clear the counter and go to START.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, clear decimation and timeout counters, and force fft_start_o=0, vga_swap_o=0, busy_o=0, timeout_o=0, frame_cnt_o=0, drop_cnt_o=0.
REQ-030 Reset mid-RUN SHALL abandon the frame; no vga_swap_o is issued for it after release.
REQ-031 timeout_o SHALL be cleared only by rst.

Configuration
REQ-032 Macro SEQ_STATS_EN defined SHALL compile in the frame_cnt_o and drop_cnt_o counters as specified.
REQ-033 Without SEQ_STATS_EN the ports SHALL remain, tied to 0; all sequencing behaviour is unchanged.

Structure
REQ-034 Shared package spectrum_pkg SHALL hold the state enumeration, FRAME_CNT_W=16 and DROP_CNT_W=8.
REQ-035 RUN-state timeout counting SHALL be one sub-module, seq_watchdog (inputs clear and enable; output expired).

Verification
REQ-036 decim_i=0, buff_start_i at cycle 10, fft_done_i at 50, vga_busy_i=0 -> fft_start_o at 11, vga_swap_o at 52, frame_cnt_o=1.
REQ-037 decim_i=2, 6 buff_start_i pulses with each frame completed -> exactly 2 fft_start_o pulses, on the 3rd and 6th input pulses.
REQ-038 300 buff_start_i pulses during RUN -> drop_cnt_o=255, state unaffected.
REQ-039 TIMEOUT_CYCLES=16, no fft_done_i -> timeout_o=1 after 16 RUN cycles, busy_o=0, no vga_swap_o; a later fft_done_i is ignored.
REQ-040 fft_done_i with vga_busy_i=1 for 100 cycles -> vga_swap_o one cycle after vga_busy_i falls.
REQ-041 rst pulse during RUN, then fft_done_i -> all outputs 0, no vga_swap_o, state IDLE.
